// File: rtl/wb_event_checker.sv
// rtl/wb_event_checker.sv - in-order register-writeback scoreboard with pass/fail counts and watchdog
module wb_event_checker #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int DEPTH          = 8,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int IGNORE_R0      = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      exp_valid,
   output logic                      exp_ready,
   input  logic [REG_ADDR_WIDTH-1:0] exp_reg,
   input  logic [DATA_WIDTH-1:0]     exp_data,
   input  logic                      wb_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0] wb_write_reg,
   input  logic [DATA_WIDTH-1:0]     wb_write_data,
   output logic [CNT_WIDTH-1:0]      pass_count,
   output logic [CNT_WIDTH-1:0]      fail_count,
   output logic [$clog2(DEPTH):0]    pending,
   output logic [REG_ADDR_WIDTH-1:0] first_fail_reg,
   output logic [DATA_WIDTH-1:0]     first_fail_data,
   output logic                      error,
   output logic                      timeout,
   output logic                      done
);

   localparam int PTRW = $clog2(DEPTH);
   localparam int PW   = PTRW + 1;
   localparam int WDW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [PW-1:0]  FULL_P = PW'(DEPTH);
   localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT, FAULT} state_t;

   state_t state, state_next;

   logic [REG_ADDR_WIDTH-1:0] mem_reg  [DEPTH];
   logic [DATA_WIDTH-1:0]     mem_data [DEPTH];
   logic [PTRW-1:0]           wr_ptr, rd_ptr;
   logic [WDW-1:0]            wd, wd_next;
   logic [PW-1:0]             pending_next;

   logic sync_rst;
   logic push, pop, check_ev, match, fail_ev;
   logic error_next, timeout_next;

   assign sync_rst  = !rst || clr;
   assign exp_ready = (pending != FULL_P);
   assign push      = exp_valid && exp_ready;
   assign check_ev  = wb_reg_write && ((IGNORE_R0 == 0) || (wb_write_reg != '0));
   assign pop       = check_ev && (pending != '0);
   assign match     = pop && (mem_reg[rd_ptr] == wb_write_reg) && (mem_data[rd_ptr] == wb_write_data);
   assign fail_ev   = check_ev && !match;

   always_comb begin
      pending_next = pending;
      case ({push, pop})
         2'b10:   pending_next = pending + PW'(1);
         2'b01:   pending_next = pending - PW'(1);
         default: pending_next = pending;
      endcase
   end

   // Watchdog only runs while expectations are outstanding and nothing is being written back.
   always_comb begin
      wd_next = wd;
      if (check_ev || (pending == '0)) begin
         wd_next = '0;
      end else if (wd != WD_MAX) begin
         wd_next = wd + WDW'(1);
      end
   end

   assign error_next   = error | fail_ev;
   assign timeout_next = timeout | (wd_next == WD_MAX);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (push) state_next = WAIT;
         WAIT:    if (pop && !push && (pending == PW'(1))) state_next = IDLE;
         FAULT:   state_next = FAULT;
         default: state_next = IDLE;
      endcase
      if (error_next || timeout_next) begin
         state_next = FAULT;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !sync_rst) begin
         mem_reg[wr_ptr]  <= exp_reg;
         mem_data[wr_ptr] <= exp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state           <= IDLE;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         pending         <= '0;
         wd              <= '0;
         pass_count      <= '0;
         fail_count      <= '0;
         first_fail_reg  <= '0;
         first_fail_data <= '0;
         error           <= 1'b0;
         timeout         <= 1'b0;
         done            <= 1'b0;
      end else begin
         state   <= state_next;
         pending <= pending_next;
         wd      <= wd_next;
         timeout <= timeout_next;
         error   <= error_next;
         if (push) wr_ptr <= wr_ptr + PTRW'(1);
         if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
         if (match && (pass_count != '1)) pass_count <= pass_count + CNT_WIDTH'(1);
         if (fail_ev && (fail_count != '1)) fail_count <= fail_count + CNT_WIDTH'(1);
         if (fail_ev && !error) begin
            first_fail_reg  <= wb_write_reg;
            first_fail_data <= wb_write_data;
         end
         done <= (pending == '0) && !error && !timeout && (pass_count != '0);
      end
   end

endmodule

// File: tb/tb_wb_event_checker.sv
// tb/tb_wb_event_checker.sv - directed self-checking bench for wb_event_checker
module tb_wb_event_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic        exp_valid = 1'b0;
   logic        exp_ready;
   logic [4:0]  exp_reg = '0;
   logic [31:0] exp_data = '0;
   logic        wb_reg_write = 1'b0;
   logic [4:0]  wb_write_reg = '0;
   logic [31:0] wb_write_data = '0;
   logic [15:0] pass_count, fail_count;
   logic [3:0]  pending;
   logic [4:0]  first_fail_reg;
   logic [31:0] first_fail_data;
   logic        error, timeout, done;

   int checks = 0;
   int errors = 0;

   wb_event_checker dut (
      .clk(clk), .rst(rst), .clr(clr),
      .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_reg(exp_reg), .exp_data(exp_data),
      .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
      .pass_count(pass_count), .fail_count(fail_count), .pending(pending),
      .first_fail_reg(first_fail_reg), .first_fail_data(first_fail_data),
      .error(error), .timeout(timeout), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic soft_clear();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic offer(input logic [4:0] r, input logic [31:0] d);
      exp_valid = 1'b1;
      exp_reg   = r;
      exp_data  = d;
   endtask

   task automatic wb(input logic [4:0] r, input logic [31:0] d);
      wb_reg_write  = 1'b1;
      wb_write_reg  = r;
      wb_write_data = d;
   endtask

   task automatic idle();
      exp_valid    = 1'b0;
      wb_reg_write = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pending"}, 64'(pending), 64'd0);
      check({tag, "_ready"}, 64'(exp_ready), 64'd1);
      check({tag, "_pass"}, 64'(pass_count), 64'd0);
      check({tag, "_fail"}, 64'(fail_count), 64'd0);
      check({tag, "_ffreg"}, 64'(first_fail_reg), 64'd0);
      check({tag, "_ffdata"}, 64'(first_fail_data), 64'd0);
      check({tag, "_err_to_done"}, 64'({error, timeout, done}), 64'd0);
   endtask

   initial begin
      step();
      step();
      rst = 1'b1;
      check_reset_state("rst");

      // Single matching writeback.
      offer(5'd3, 32'hE);
      step();
      idle();
      wb(5'd3, 32'hE);
      step();
      idle();
      check("or_pass", 64'(pass_count), 64'd1);
      check("or_fail", 64'(fail_count), 64'd0);
      check("or_pending", 64'(pending), 64'd0);
      check("or_done_early", 64'(done), 64'd0);
      step();
      check("or_done", 64'(done), 64'd1);

      // Mismatch then match; first failure captured.
      soft_clear();
      offer(5'd3, 32'hE);
      step();
      offer(5'd4, 32'h1);
      step();
      idle();
      wb(5'd3, 32'hF);
      step();
      wb(5'd4, 32'h1);
      step();
      idle();
      step();
      check("mm_pass", 64'(pass_count), 64'd1);
      check("mm_fail", 64'(fail_count), 64'd1);
      check("mm_ffreg", 64'(first_fail_reg), 64'd3);
      check("mm_ffdata", 64'(first_fail_data), 64'hF);
      check("mm_error", 64'(error), 64'd1);
      check("mm_done", 64'(done), 64'd0);

      // Fill, ignored ninth offer, overlapping push/pop across the wrap.
      soft_clear();
      for (int i = 0; i < 8; i++) begin
         offer(5'(i + 1), 32'h100 + 32'(i));
         step();
      end
      check("full_pending", 64'(pending), 64'd8);
      check("full_ready", 64'(exp_ready), 64'd0);
      offer(5'd20, 32'hDEAD);
      step();
      idle();
      check("full_ninth", 64'(pending), 64'd8);
      for (int i = 0; i < 3; i++) begin
         wb(5'(i + 1), 32'h100 + 32'(i));
         step();
      end
      idle();
      check("pop3_pending", 64'(pending), 64'd5);
      for (int i = 0; i < 3; i++) begin
         offer(5'(i + 9), 32'h108 + 32'(i));
         wb(5'(i + 4), 32'h103 + 32'(i));
         step();
      end
      idle();
      check("pushpop_pending", 64'(pending), 64'd5);
      for (int i = 6; i < 11; i++) begin
         wb(5'(i + 1), 32'h100 + 32'(i));
         step();
      end
      idle();
      check("wrap_pass", 64'(pass_count), 64'd11);
      check("wrap_pending", 64'(pending), 64'd0);
      check("wrap_fail", 64'(fail_count), 64'd0);
      check("wrap_error", 64'(error), 64'd0);

      // Push and check on the same edge into an empty queue.
      soft_clear();
      offer(5'd5, 32'h7);
      wb(5'd5, 32'h7);
      step();
      idle();
      check("sim_fail", 64'(fail_count), 64'd1);
      check("sim_pass0", 64'(pass_count), 64'd0);
      check("sim_pending", 64'(pending), 64'd1);
      wb(5'd5, 32'h7);
      step();
      idle();
      check("sim_pass", 64'(pass_count), 64'd1);
      check("sim_pending0", 64'(pending), 64'd0);

      // x0 write ignored; watchdog expires after 64 idle cycles.
      soft_clear();
      offer(5'd1, 32'h2);
      step();
      idle();
      wb(5'd0, 32'h9);
      step();
      idle();
      check("x0_counts", 64'({pass_count, fail_count}), 64'd0);
      check("x0_pending", 64'(pending), 64'd1);
      repeat (62) step();
      check("to_before", 64'(timeout), 64'd0);
      step();
      check("to_set", 64'(timeout), 64'd1);
      check("to_error", 64'(error), 64'd0);

      // Hard reset in the middle of a run.
      soft_clear();
      wb(5'd7, 32'h1);
      step();
      step();
      idle();
      for (int i = 0; i < 4; i++) begin
         offer(5'(i + 6), 32'h20 + 32'(i));
         step();
      end
      idle();
      check("mid_pending", 64'(pending), 64'd4);
      check("mid_fail", 64'(fail_count), 64'd2);
      rst = 1'b0;
      step();
      rst = 1'b1;
      check_reset_state("mid_rst");
      wb(5'd7, 32'h1);
      step();
      idle();
      check("post_fail", 64'(fail_count), 64'd1);
      check("post_ffreg", 64'(first_fail_reg), 64'd7);
      check("post_pending", 64'(pending), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_event_checker.md
Name: wb_event_checker

Overview:
- Parametrised successor to the single-instruction register-writeback check: a synthesizable scoreboard that sits on the CPU register-file write port (reg_write / write_reg / write_data).
- Holds a queue of expected writebacks and compares each actual write, in order, against the queue head.
- Accumulates pass/fail counts, captures the first mismatch and runs a watchdog, so multi-instruction programs self-check in simulation or on the FPGA.

Parameters:
DATA_WIDTH, 32, width of write_data and expected data
REG_ADDR_WIDTH, 5, width of register index
DEPTH, 8, expected-queue entries (power of two, >=2)
CNT_WIDTH, 16, width of pass/fail counters
TIMEOUT_CYCLES, 64, idle cycles with pending expectations before timeout
IGNORE_R0, 1, when 1 writes to register 0 are neither checked nor counted

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (0 = reset)
clr  in  1  synchronous soft clear; same effect as reset
exp_valid  in  1  expected entry offered
exp_ready  out  1  queue can accept entry
exp_reg  in  REG_ADDR_WIDTH  expected destination register
exp_data  in  DATA_WIDTH  expected write data
wb_reg_write  in  1  register-file write strobe
wb_write_reg  in  REG_ADDR_WIDTH  actual destination register
wb_write_data  in  DATA_WIDTH  actual write data
pass_count  out  CNT_WIDTH  matched writes
fail_count  out  CNT_WIDTH  mismatched plus unexpected writes
pending  out  $clog2(DEPTH)+1  entries in queue
first_fail_reg  out  REG_ADDR_WIDTH  register of first failing write
first_fail_data  out  DATA_WIDTH  data of first failing write
error  out  1  sticky: any failure seen
timeout  out  1  sticky: watchdog expired
done  out  1  pending==0, error==0, timeout==0, pass_count>0

Behaviour:
- One clock, all state updated on rising clk. Reset is synchronous: rst==0 or clr==1 sampled at an edge.
- Reset/clear values: queue empty, pending=0, exp_ready=1, counts=0, first_fail_*=0, error=0, timeout=0, done=0, watchdog=0, state IDLE. Reset wins over any simultaneous push or check.
- Push: exp_valid && exp_ready at an edge writes the entry at the tail. exp_ready = (pending != DEPTH), computed combinationally from registered pending. Offers while full are not accepted and have no effect.
- Check event: wb_reg_write==1, and (IGNORE_R0==0 or wb_write_reg!=0).
  - Queue non-empty: compare register and data with the head, pop the head the same edge.
  - Match: pass_count+1.
  - Mismatch: fail_count+1.
  - Queue empty at the edge (unexpected write): fail_count+1, no pop.
- Push and check at the same edge: the check uses the head as it stood before the edge. An entry pushed that edge is never compared that edge. Push+pop leaves pending unchanged. Push into an empty queue plus a check counts as unexpected, and the pushed entry remains queued.
- First failure: on the first fail while error==0, latch wb_write_reg/wb_write_data into first_fail_* and set error. Later failures do not overwrite them.
- Counters saturate at all-ones, no wrap. Queue pointers wrap modulo DEPTH.
- Watchdog:
  - Increments each cycle that pending!=0 and no check event occurs.
  - Clears to 0 on any check event or when pending==0.
  - On reaching TIMEOUT_CYCLES it sets timeout (sticky) and stops counting.
- States: IDLE (pending==0), WAIT (pending!=0), FAULT (error|timeout).
  - IDLE->WAIT on a push.
  - WAIT->IDLE when the last entry pops with no push.
  - Any->FAULT when error or timeout sets. FAULT exits only by reset/clr.
  - In FAULT, queueing, comparison and counting continue.
- done is registered and updates the cycle after its conditions hold.

Test Plan:
- OR program: push (x3,0x0000000E); one cycle later write x3=0xE -> pass_count=1, fail_count=0, pending=0, done=1 one cycle later.
- Mismatch: push (x3,0xE),(x4,0x1); write x3=0xF, then x4=0x1 -> pass=1, fail=1, first_fail_reg=3, first_fail_data=0xF, error=1, state FAULT.
- Full/wrap: DEPTH=8, push 8 entries -> exp_ready=0 and a 9th offer is ignored. Pop 3 and push 3 while matching all 11 -> pass=11, pending=0, no error.
- Simultaneous: queue empty, push (x5,0x7) and write x5=0x7 the same edge -> fail=1 (unexpected), pending=1. Next-cycle write x5=0x7 -> pass=1.
- Timeout / x0: push (x1,0x2), then write x0=0x9 (ignored, counts unchanged) followed by 64 idle cycles -> timeout=1 at cycle 64, error=0.
- Reset mid-run: pending=4, fail=2, drive rst=0 for one edge -> all outputs at reset values, exp_ready=1, next check with an empty queue counts as unexpected.
